// File: rtl/topo_controlador.sv
// Whack-a-mole sequencer: cursor, mole placement, strike forwarding,
// round timing and scoring for a FILAS x COLUMNAS board of mole cells.
module topo_controlador #(
   parameter int unsigned FILAS      = 3,
   parameter int unsigned COLUMNAS   = 3,
   parameter int unsigned TICKS_TOPO = 25000000,
   parameter int unsigned RONDAS     = 30
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          START,
   input  logic                          ARRIBA,
   input  logic                          ABAJO,
   input  logic                          IZQUIERDA,
   input  logic                          DERECHA,
   input  logic                          GOLPE,
   input  logic                          HIT,
   output logic [FILAS*COLUMNAS-1:0]     PONER_TOPO,
   output logic [FILAS*COLUMNAS-1:0]     SELECT,
   output logic                          GOLPE_OUT,
   output logic [7:0]                    PUNTAJE,
   output logic [7:0]                    FALLOS,
   output logic                          JUGANDO,
   output logic                          FIN_JUEGO
);

   localparam int unsigned N     = FILAS * COLUMNAS;
   localparam int unsigned POS_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned FIL_W = (FILAS > 1) ? $clog2(FILAS) : 1;
   localparam int unsigned COL_W = (COLUMNAS > 1) ? $clog2(COLUMNAS) : 1;
   localparam int unsigned TMR_W = (TICKS_TOPO > 1) ? $clog2(TICKS_TOPO) : 1;
   localparam int unsigned RND_W = $clog2(RONDAS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_NUEVO,
      S_ACTIVO,
      S_FIN
   } estado_t;

   estado_t            estado_q, estado_d;
   logic [FIL_W-1:0]   fila_q, fila_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [TMR_W-1:0]   timer_q, timer_d;
   logic [RND_W-1:0]   ronda_q, ronda_d;
   logic [7:0]         lfsr_q, lfsr_d;
   logic               golpe_q, golpe_d;
   logic [7:0]         puntaje_q, puntaje_d;
   logic [7:0]         fallos_q, fallos_d;
   logic [N-1:0]       poner_q, poner_d;
   logic [N-1:0]       select_q, select_d;
   logic               jugando_q, jugando_d;
   logic               fin_q, fin_d;

   logic [POS_W-1:0]   pos_raw;
   logic [POS_W-1:0]   sel_idx;
   logic               hit_evt;

   // Candidate mole position and the strike outcome of this cycle
   assign pos_raw = POS_W'(lfsr_q % 8'(N));
   assign hit_evt = golpe_q && HIT;

   // Next-state, scoring, cursor and registered-output logic
   always_comb begin
      estado_d  = estado_q;
      fila_d    = fila_q;
      col_d     = col_q;
      pos_d     = pos_q;
      timer_d   = timer_q;
      ronda_d   = ronda_q;
      puntaje_d = puntaje_q;
      fallos_d  = fallos_q;
      lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      golpe_d   = GOLPE && (estado_q == S_ACTIVO);

      // A forwarded strike is scored on whatever the cells report
      if (golpe_q) begin
         if (HIT) begin
            if (puntaje_q != 8'hFF) puntaje_d = puntaje_q + 8'd1;
         end else if (fallos_q != 8'hFF) begin
            fallos_d = fallos_q + 8'd1;
         end
      end

      case (estado_q)
         S_IDLE, S_FIN: begin
            if (START) begin
               estado_d  = S_NUEVO;
               puntaje_d = '0;
               fallos_d  = '0;
               ronda_d   = '0;
            end
         end
         S_NUEVO: begin
            // Never place the mole twice in a row on the same cell
            if (pos_raw == pos_q) begin
               pos_d = (pos_raw == POS_W'(N - 1)) ? '0 : pos_raw + POS_W'(1);
            end else begin
               pos_d = pos_raw;
            end
            timer_d  = TMR_W'(TICKS_TOPO - 1);
            estado_d = S_ACTIVO;
         end
         S_ACTIVO: begin
            // A hit in the last timer cycle still closes the round as a hit
            if (hit_evt || (timer_q == '0)) begin
               ronda_d  = ronda_q + RND_W'(1);
               estado_d = (ronda_d == RND_W'(RONDAS)) ? S_FIN : S_NUEVO;
            end else begin
               timer_d = timer_q - TMR_W'(1);
            end
         end
         default: estado_d = S_IDLE;
      endcase

      // Opposite pulses on one axis cancel; the two axes are independent
      if (ARRIBA && !ABAJO) begin
         fila_d = (fila_q == '0) ? FIL_W'(FILAS - 1) : fila_q - FIL_W'(1);
      end else if (ABAJO && !ARRIBA) begin
         fila_d = (fila_q == FIL_W'(FILAS - 1)) ? '0 : fila_q + FIL_W'(1);
      end
      if (IZQUIERDA && !DERECHA) begin
         col_d = (col_q == '0) ? COL_W'(COLUMNAS - 1) : col_q - COL_W'(1);
      end else if (DERECHA && !IZQUIERDA) begin
         col_d = (col_q == COL_W'(COLUMNAS - 1)) ? '0 : col_q + COL_W'(1);
      end

      sel_idx   = POS_W'(fila_d) * POS_W'(COLUMNAS) + POS_W'(col_d);
      select_d  = N'(1) << sel_idx;
      poner_d   = (estado_d == S_ACTIVO) ? (N'(1) << pos_d) : '0;
      jugando_d = (estado_d == S_NUEVO) || (estado_d == S_ACTIVO);
      fin_d     = (estado_d == S_FIN);
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_q  <= S_IDLE;
         fila_q    <= '0;
         col_q     <= '0;
         pos_q     <= '0;
         timer_q   <= '0;
         ronda_q   <= '0;
         lfsr_q    <= 8'hA5;
         golpe_q   <= 1'b0;
         puntaje_q <= '0;
         fallos_q  <= '0;
         poner_q   <= '0;
         select_q  <= N'(1);
         jugando_q <= 1'b0;
         fin_q     <= 1'b0;
      end else begin
         estado_q  <= estado_d;
         fila_q    <= fila_d;
         col_q     <= col_d;
         pos_q     <= pos_d;
         timer_q   <= timer_d;
         ronda_q   <= ronda_d;
         lfsr_q    <= lfsr_d;
         golpe_q   <= golpe_d;
         puntaje_q <= puntaje_d;
         fallos_q  <= fallos_d;
         poner_q   <= poner_d;
         select_q  <= select_d;
         jugando_q <= jugando_d;
         fin_q     <= fin_d;
      end
   end

   assign PONER_TOPO = poner_q;
   assign SELECT     = select_q;
   assign GOLPE_OUT  = golpe_q;
   assign PUNTAJE    = puntaje_q;
   assign FALLOS     = fallos_q;
   assign JUGANDO    = jugando_q;
   assign FIN_JUEGO  = fin_q;

endmodule

// File: tb/tb_topo_controlador.sv
// Bench for topo_controlador: cycle model feeding an expected-output queue,
// with a simple cell model closing the HIT loop.
module tb_topo_controlador;

   localparam int unsigned FILS = 3;
   localparam int unsigned COLS = 3;
   localparam int unsigned N    = FILS * COLS;
   localparam int unsigned T    = 4;
   localparam int unsigned R    = 300;

   localparam int ST_IDLE  = 0;
   localparam int ST_NUEVO = 1;
   localparam int ST_ACT   = 2;
   localparam int ST_FIN   = 3;

   typedef struct {
      logic [N-1:0] sel;
      logic [N-1:0] poner;
      bit           poner_known;
      logic         golpe;
      logic [7:0]   punt;
      logic [7:0]   fall;
      logic         jug;
      logic         fin;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start, arriba, abajo, izq, der, golpe;
   logic          hit;
   logic [N-1:0]  poner, sel;
   logic          golpe_out, jugando, fin_juego;
   logic [7:0]    puntaje, fallos;

   int n_cmp = 0;
   int n_err = 0;
   exp_t sb[$];

   // Model state
   int m_state, m_fila, m_col, m_timer, m_ronda, m_punt, m_fall, m_pos, m_prev;
   bit m_golpe;

   topo_controlador #(
      .FILAS(FILS), .COLUMNAS(COLS), .TICKS_TOPO(T), .RONDAS(R)
   ) dut (
      .clk(clk), .reset(reset), .START(start),
      .ARRIBA(arriba), .ABAJO(abajo), .IZQUIERDA(izq), .DERECHA(der),
      .GOLPE(golpe), .HIT(hit),
      .PONER_TOPO(poner), .SELECT(sel), .GOLPE_OUT(golpe_out),
      .PUNTAJE(puntaje), .FALLOS(fallos), .JUGANDO(jugando), .FIN_JUEGO(fin_juego)
   );

   // A cell reports HIT when the strike reaches the selected cell holding the mole
   assign hit = golpe_out & (|(poner & sel));

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = ST_IDLE; m_fila = 0; m_col = 0; m_timer = 0; m_ronda = 0;
      m_punt = 0; m_fall = 0; m_pos = -1; m_prev = 0; m_golpe = 1'b0;
   endtask

   // Advance the model by one clock edge using the inputs currently driven
   task automatic model_step();
      int st_old;
      bit hit_now;
      st_old  = m_state;
      hit_now = m_golpe && (st_old == ST_ACT) && (m_pos == m_fila * COLS + m_col);
      if (m_golpe) begin
         if (hit_now) m_punt = (m_punt < 255) ? m_punt + 1 : 255;
         else         m_fall = (m_fall < 255) ? m_fall + 1 : 255;
      end
      case (st_old)
         ST_IDLE, ST_FIN: if (start) begin
            m_state = ST_NUEVO; m_punt = 0; m_fall = 0; m_ronda = 0;
         end
         ST_NUEVO: begin
            m_state = ST_ACT; m_timer = T - 1; m_pos = -1;
         end
         ST_ACT: if (hit_now || m_timer == 0) begin
            m_ronda++;
            m_state = (m_ronda == R) ? ST_FIN : ST_NUEVO;
         end else begin
            m_timer--;
         end
         default: ;
      endcase
      m_golpe = golpe && (st_old == ST_ACT);
      if (arriba && !abajo) m_fila = (m_fila + FILS - 1) % FILS;
      if (abajo && !arriba) m_fila = (m_fila + 1) % FILS;
      if (izq && !der)      m_col  = (m_col + COLS - 1) % COLS;
      if (der && !izq)      m_col  = (m_col + 1) % COLS;
   endtask

   function automatic exp_t model_outputs();
      exp_t e;
      e.sel = '0;
      e.sel[m_fila * COLS + m_col] = 1'b1;
      e.poner = '0;
      e.poner_known = !((m_state == ST_ACT) && (m_pos < 0));
      if ((m_state == ST_ACT) && (m_pos >= 0)) e.poner[m_pos] = 1'b1;
      e.golpe = m_golpe;
      e.punt  = 8'(m_punt);
      e.fall  = 8'(m_fall);
      e.jug   = (m_state == ST_NUEVO) || (m_state == ST_ACT);
      e.fin   = (m_state == ST_FIN);
      return e;
   endfunction

   // First cycle of a round: the mole must be one-hot and on a new cell
   task automatic adopt_mole();
      int p;
      p = -1;
      check_eq("mole_onehot", 32'($countones(poner)), 32'd1);
      for (int i = 0; i < N; i++) if (poner[i]) p = i;
      check_eq("mole_moved", 32'(p != m_prev), 32'd1);
      if (p < 0) p = 0;
      m_pos  = p;
      m_prev = p;
   endtask

   // One clock: push the model's expectation, clock the DUT, pop and compare
   task automatic cycle();
      exp_t e;
      model_step();
      sb.push_back(model_outputs());
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check_eq("SELECT", 32'(sel), 32'(e.sel));
      if (!e.poner_known) adopt_mole();
      else check_eq("PONER_TOPO", 32'(poner), 32'(e.poner));
      check_eq("GOLPE_OUT", 32'(golpe_out), 32'(e.golpe));
      check_eq("PUNTAJE", 32'(puntaje), 32'(e.punt));
      check_eq("FALLOS", 32'(fallos), 32'(e.fall));
      check_eq("JUGANDO", 32'(jugando), 32'(e.jug));
      check_eq("FIN_JUEGO", 32'(fin_juego), 32'(e.fin));
      {start, arriba, abajo, izq, der, golpe} = '0;
   endtask

   // Move the cursor to a cell with one combined pulse, optionally striking too
   task automatic aim(input int tgt, input bit strike);
      int dv, dh;
      dv = (tgt / COLS - m_fila + FILS) % FILS;
      dh = (tgt % COLS - m_col + COLS) % COLS;
      abajo  = (dv == 1);
      arriba = (dv == 2);
      der    = (dh == 1);
      izq    = (dh == 2);
      golpe  = strike;
      cycle();
   endtask

   task automatic run_to_fin(input string tag);
      int n;
      n = 0;
      while (fin_juego !== 1'b1 && n < int'(R * (T + 1) + 10)) begin
         cycle();
         n++;
      end
      check_eq(tag, 32'(fin_juego), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_select"}, 32'(sel), 32'd1);
      check_eq({tag, "_poner"}, 32'(poner), 32'd0);
      check_eq({tag, "_golpe"}, 32'(golpe_out), 32'd0);
      check_eq({tag, "_puntaje"}, 32'(puntaje), 32'd0);
      check_eq({tag, "_fallos"}, 32'(fallos), 32'd0);
      check_eq({tag, "_jugando"}, 32'(jugando), 32'd0);
      check_eq({tag, "_fin"}, 32'(fin_juego), 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      {start, arriba, abajo, izq, der, golpe} = '0;
      reset = 1'b1;
      #1 reset = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("rst");
      reset = 1'b1;

      // Idle after reset, strike ignored in IDLE
      repeat (20) cycle();
      check_eq("idle_select", 32'(sel), 32'd1);
      golpe = 1'b1;
      cycle();
      check_eq("golpe_idle", 32'(golpe_out), 32'd0);

      // Cursor wrapping and simultaneous pulses
      izq = 1'b1;                cycle(); check_eq("cur_izq", 32'(sel), 32'h004);
      arriba = 1'b1;             cycle(); check_eq("cur_arriba", 32'(sel), 32'h100);
      arriba = 1'b1; abajo = 1'b1; cycle(); check_eq("cur_both_v", 32'(sel), 32'h100);
      der = 1'b1; abajo = 1'b1;  cycle(); check_eq("cur_diag", 32'(sel), 32'h001);

      // Full game with no strikes; START ignored while playing
      start = 1'b1; cycle();
      check_eq("nuevo_no_mole", 32'(poner), 32'd0);
      start = 1'b1; cycle();
      run_to_fin("game_timeout_fin");
      check_eq("timeout_puntaje", 32'(puntaje), 32'd0);
      check_eq("timeout_fallos", 32'(fallos), 32'd0);

      // Miss then hit in one round
      start = 1'b1; cycle();
      cycle();
      aim((m_pos + 1) % N, 1'b1);
      check_eq("miss_golpe_out", 32'(golpe_out), 32'd1);
      aim(m_pos, 1'b1);
      check_eq("miss_fallos", 32'(fallos), 32'd1);
      check_eq("miss_mole_up", 32'($countones(poner)), 32'd1);
      cycle();
      check_eq("hit_puntaje", 32'(puntaje), 32'd1);
      check_eq("hit_round_end", 32'(poner), 32'd0);

      // Hit landing in the timer==0 cycle
      cycle();
      aim(m_pos, 1'b0);
      cycle();
      golpe = 1'b1; cycle();
      check_eq("late_golpe_out", 32'(golpe_out), 32'd1);
      cycle();
      check_eq("late_hit_puntaje", 32'(puntaje), 32'd2);
      check_eq("late_hit_fallos", 32'(fallos), 32'd1);

      // Strike during NUEVO is dropped
      golpe = 1'b1; cycle();
      check_eq("golpe_nuevo", 32'(golpe_out), 32'd0);
      run_to_fin("game_mixed_fin");

      // Strike during FIN is dropped, counters held
      golpe = 1'b1; cycle();
      check_eq("golpe_fin", 32'(golpe_out), 32'd0);
      cycle();
      check_eq("fin_puntaje_held", 32'(puntaje), 32'd2);
      check_eq("fin_fallos_held", 32'(fallos), 32'd1);

      // Hit every round: score saturates
      start = 1'b1; cycle();
      for (int r = 0; r < int'(R) && fin_juego !== 1'b1; r++) begin
         cycle();
         aim(m_pos, 1'b1);
         cycle();
      end
      check_eq("sat_fin", 32'(fin_juego), 32'd1);
      check_eq("sat_puntaje", 32'(puntaje), 32'd255);
      check_eq("sat_fallos", 32'(fallos), 32'd0);

      // Asynchronous reset in the middle of ACTIVO
      start = 1'b1; cycle();
      cycle();
      cycle();
      #2 reset = 1'b0;
      #1;
      check_reset_outputs("async");
      model_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) cycle();
      check_eq("post_reset_idle", 32'(jugando), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
